spinnaker_fpgas_spi_reg_if: RTL and testbench
=============================================

# spinnaker_fpgas_spi_reg_if

SPI slave that gives the board management processor access to the top-level control/diagnostic register bank. It sits directly upstream of the register bank. It decodes SPI frames into single-cycle register writes and combinational-read captures, all in the system clock domain, and shifts read data back out on MISO.

## Interface
Parameters:
- REGA_BITS, 14, register address width (must be ≤ 16)
- REGD_BITS, 32, register data width

Ports:
- CLK_IN  input  1  system clock; SPI pins are oversampled in this domain
- RESET_IN  input  1  reset; one clock domain, reset is synchronous and active-high
- SPI_NSS_IN  input  1  SPI chip select, active low, asynchronous to CLK_IN
- SPI_SCLK_IN  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous
- SPI_MOSI_IN  input  1  master-out data, MSB first
- SPI_MISO_OUT  output  1  slave-out data, MSB first
- WRITE_OUT  output  1  one-cycle register write strobe to the register bank
- ADDR_OUT  output  REGA_BITS  register address to the register bank (read and write)
- WRITE_DATA_OUT  output  REGD_BITS  write data to the register bank
- READ_DATA_IN  input  REGD_BITS  combinational read data from the register bank

## Operation
- Frame format, all fields MSB first, framed by NSS low:
  - 8-bit command: 0x02 = write, 0x03 = read.
  - 16-bit address: low REGA_BITS bits are used; upper bits are ignored.
  - REGD_BITS data bits.
- Synchronisation: NSS, SCLK and MOSI each pass through a 2-flop synchroniser, then a third register for edge detection.
  - MOSI is sampled on the detected SCLK rising edge.
  - MISO changes on the detected SCLK falling edge.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE. A bit counter of 6 bits counts bits within the current field.
  - IDLE → CMD on synchronised NSS falling edge; counter cleared.
  - CMD → ADDR after 8 bits if the command is 0x02 or 0x03; otherwise CMD → IGNORE.
  - ADDR → DATA after 16 bits. ADDR_OUT is loaded from the address shifter in the same cycle.
  - DATA, write: after REGD_BITS bits, WRITE_DATA_OUT is loaded and WRITE_OUT pulses high for exactly 1 cycle; then → IGNORE.
  - DATA, read: after REGD_BITS bits → IGNORE; no write.
  - IGNORE: extra SCLK edges are discarded until NSS rises.
  - Any state → IDLE on synchronised NSS rising edge. An incomplete frame is aborted with no write and no register change.
- Read path:
  - The cycle after ADDR_OUT updates, READ_DATA_IN is captured into the MISO shifter.
  - The MSB is driven onto MISO at the next SCLK falling edge, i.e. the one after the last address bit.
  - Subsequent bits follow, one per falling edge.
  - MISO is 0 in IDLE, CMD, ADDR, IGNORE, and during DATA of a write.
- ADDR_OUT and WRITE_DATA_OUT hold their last values between frames.
- Reset values: state IDLE, WRITE_OUT 0, ADDR_OUT 0, WRITE_DATA_OUT 0, SPI_MISO_OUT 0, counters and shifters 0.
- Reset mid-frame: the FSM returns to IDLE. Remaining SCLK edges of that frame are ignored until NSS has been seen high and then falls again.

## Timing
- Input-to-edge-detect latency: 3 CLK_IN cycles.
- SCLK high and low phases must each be ≥ 4 CLK_IN periods, so f_SCLK ≤ f_CLK/8.
- WRITE_OUT asserts 1 cycle after the cycle in which the last data bit is registered.
  - WRITE_DATA_OUT and ADDR_OUT are stable in that same cycle.
  - WRITE_OUT is never asserted for 2 consecutive cycles.
- Read capture occurs 2 cycles after the final address-bit rising edge is detected. The capture well precedes the next falling edge.
- NSS rising edge coincident with the final data-bit rising edge: the bit is processed first, then abort. A complete write therefore still commits.
- Back-to-back frames need NSS high for ≥ 4 CLK_IN cycles.

## Structure
- Package spinnaker_fpgas_spi_pkg:
  - opcode constants SPI_CMD_WRITE = 8'h02 and SPI_CMD_READ = 8'h03
  - field widths CMD_BITS = 8 and ADDR_FIELD_BITS = 16
  - FSM state encoding
- Sub-module spinnaker_fpgas_spi_sync: one instance per SPI input, providing the 2-flop synchroniser plus rise/fall pulse outputs.

## Test plan
- Write 0x02, addr 0x0002, data 0xDEADBEEF → ADDR_OUT=2, WRITE_DATA_OUT=0xDEADBEEF, WRITE_OUT high for exactly one cycle.
- Read 0x03, addr 0x0005, with READ_DATA_IN=0x0000003C for that address → MISO yields 0x0000003C MSB first; WRITE_OUT stays 0.
- Unknown command 0x7F followed by 48 bits → no WRITE_OUT, MISO 0 throughout, the next valid frame works normally.
- Write aborted by NSS rising after 20 data bits → WRITE_OUT never asserts, WRITE_DATA_OUT keeps its previous value.
- Address 0xC003 with REGA_BITS=14 → ADDR_OUT=0x0003.
- RESET_IN pulsed mid-read → all outputs return to 0; a read of addr 0 in the following frame returns the VERSION value.

Source files
------------

// File: rtl/spinnaker_fpgas_spi_pkg.sv
// Shared constants and FSM encoding for the SPI register-access slave.
package spinnaker_fpgas_spi_pkg;

    localparam logic [7:0] SPI_CMD_WRITE   = 8'h02;
    localparam logic [7:0] SPI_CMD_READ    = 8'h03;
    localparam int         CMD_BITS        = 8;
    localparam int         ADDR_FIELD_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } spi_state_e;

endpackage

// File: rtl/spinnaker_fpgas_spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus a third stage
// that turns level changes into single-cycle rise/fall pulses.
module spinnaker_fpgas_spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb sync_d = {sync_q[1:0], d};

    // Resetting to 0 means a pin already low at reset yields no falling
    // edge, so a frame interrupted by reset cannot restart mid-way.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q    = sync_q[1];
    assign rise =  sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spinnaker_fpgas_spi_reg_if.sv
// SPI mode-0 slave decoding write/read frames into register-bank accesses,
// entirely in the CLK_IN domain by oversampling the SPI pins.
module spinnaker_fpgas_spi_reg_if
    import spinnaker_fpgas_spi_pkg::*;
#(
    parameter int REGA_BITS = 14,
    parameter int REGD_BITS = 32
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_IN,
    input  logic                 SPI_NSS_IN,
    input  logic                 SPI_SCLK_IN,
    input  logic                 SPI_MOSI_IN,
    output logic                 SPI_MISO_OUT,
    output logic                 WRITE_OUT,
    output logic [REGA_BITS-1:0] ADDR_OUT,
    output logic [REGD_BITS-1:0] WRITE_DATA_OUT,
    input  logic [REGD_BITS-1:0] READ_DATA_IN
);

    localparam int SH_W = (REGD_BITS > ADDR_FIELD_BITS) ? REGD_BITS : ADDR_FIELD_BITS;

    logic nss_q, nss_rise, nss_fall;
    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    spinnaker_fpgas_spi_sync u_sync_nss (
        .clk(CLK_IN), .rst(RESET_IN), .d(SPI_NSS_IN),
        .q(nss_q), .rise(nss_rise), .fall(nss_fall)
    );
    spinnaker_fpgas_spi_sync u_sync_sclk (
        .clk(CLK_IN), .rst(RESET_IN), .d(SPI_SCLK_IN),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    spinnaker_fpgas_spi_sync u_sync_mosi (
        .clk(CLK_IN), .rst(RESET_IN), .d(SPI_MOSI_IN),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, nss_q, sclk_q, mosi_rise, mosi_fall};

    spi_state_e           state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [SH_W-1:0]      shift_q, shift_d, shift_in;
    logic                 is_wr_q, is_wr_d;
    logic [REGA_BITS-1:0] addr_q, addr_d;
    logic [REGD_BITS-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 cap_q, cap_d;
    logic [REGD_BITS-1:0] miso_sh_q, miso_sh_d;
    logic                 miso_q, miso_d;

    assign shift_in = {shift_q[SH_W-2:0], mosi_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = 1'b0;
        cap_d     = 1'b0;
        miso_sh_d = miso_sh_q;
        miso_d    = miso_q;

        case (state_q)
            ST_IDLE: begin
                if (nss_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 6'd1;
                    if (state_q == ST_CMD && cnt_q == 6'(CMD_BITS - 1)) begin
                        cnt_d   = '0;
                        is_wr_d = (shift_in[7:0] == SPI_CMD_WRITE);
                        if (shift_in[7:0] == SPI_CMD_WRITE || shift_in[7:0] == SPI_CMD_READ)
                            state_d = ST_ADDR;
                        else
                            state_d = ST_IGNORE;
                    end else if (state_q == ST_ADDR && cnt_q == 6'(ADDR_FIELD_BITS - 1)) begin
                        cnt_d   = '0;
                        addr_d  = shift_in[REGA_BITS-1:0];
                        state_d = ST_DATA;
                        cap_d   = ~is_wr_q;
                    end else if (state_q == ST_DATA && cnt_q == 6'(REGD_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IGNORE;
                        if (is_wr_q) begin
                            wdata_d = shift_in[REGD_BITS-1:0];
                            write_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Capture one cycle after ADDR_OUT settles so the bank's combinational
        // read path sees the new address.
        if (cap_q)
            miso_sh_d = READ_DATA_IN;
        if (state_q == ST_DATA && !is_wr_q && sclk_fall) begin
            miso_d    = miso_sh_q[REGD_BITS-1];
            miso_sh_d = {miso_sh_q[REGD_BITS-2:0], 1'b0};
        end

        // NSS rise wins last so a coincident final bit still commits.
        if (nss_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
        if (!(state_d == ST_DATA && !is_wr_d))
            miso_d = 1'b0;
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            cap_q     <= 1'b0;
            miso_sh_q <= '0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            cap_q     <= cap_d;
            miso_sh_q <= miso_sh_d;
            miso_q    <= miso_d;
        end
    end

    assign SPI_MISO_OUT   = miso_q;
    assign WRITE_OUT      = write_q;
    assign ADDR_OUT       = addr_q;
    assign WRITE_DATA_OUT = wdata_q;

endmodule

// File: tb/tb_spinnaker_fpgas_spi_reg_if.sv
// Bench for the SPI register-access slave: table of frames plus reset and
// coincident-NSS sequences, with a write scoreboard on WRITE_OUT.
module tb_spinnaker_fpgas_spi_reg_if;

    localparam int HALF = 6;
    localparam logic [31:0] VERSION = 32'h0102_0304;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nss = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [31:0] data;
        int          ndata;
        bit          coinc;
        bit          exp_wr;
        logic [13:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_miso;
    } vec_t;

    always #5 clk = ~clk;

    function automatic logic [31:0] bank(input logic [13:0] a);
        if (a == 14'd0)      return VERSION;
        else if (a == 14'd5) return 32'h0000_003C;
        else                 return {16'hA5A5, 2'b00, a};
    endfunction

    assign rdata = bank(addr);

    spinnaker_fpgas_spi_reg_if #(.REGA_BITS(14), .REGD_BITS(32)) dut (
        .CLK_IN(clk), .RESET_IN(rst),
        .SPI_NSS_IN(nss), .SPI_SCLK_IN(sclk), .SPI_MOSI_IN(mosi),
        .SPI_MISO_OUT(miso), .WRITE_OUT(wr),
        .ADDR_OUT(addr), .WRITE_DATA_OUT(wdata), .READ_DATA_IN(rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every WRITE_OUT pulse must match the oldest expected write.
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        prev_wr <= wr;
        if (wr) begin
            if (prev_wr) begin
                nvec++; nmis++;
                $display("FAIL write_double: got 2 consecutive strobes expected 1");
            end else if (exp_q.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL write_unexpected: got addr %h data %h expected none", addr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {18'd0, addr}, {18'd0, e.addr});
                chk("write_data", wdata, e.data);
            end
        end
    end

    task automatic frame(input logic [7:0] cmd, input logic [15:0] fa, input logic [31:0] fd,
                         input int ndata, input bit coinc, input int rst_at,
                         output logic [31:0] mw, output bit mnz);
        logic [55:0] w;
        int nb;
        w  = {cmd, fa, fd};
        nb = 24 + ndata;
        mw = '0;
        mnz = 1'b0;
        @(negedge clk) nss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            mosi = w[55-i];
            repeat (HALF) @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_write", {31'd0, wr}, 32'd0);
                chk("rst_mid_addr", {18'd0, addr}, 32'd0);
                chk("rst_mid_wdata", wdata, 32'd0);
                chk("rst_mid_miso", {31'd0, miso}, 32'd0);
                mnz = 1'b0;
            end
            if (miso) mnz = 1'b1;
            if (i >= 24) mw = {mw[30:0], miso};
            sclk = 1'b1;
            if (coinc && i == nb - 1) nss = 1'b1;
            repeat (HALF) @(negedge clk);
            if (miso) mnz = 1'b1;
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        nss  = 1'b1;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] mw;
        bit          mnz;

        vecs[0] = '{8'h02, 16'h0002, 32'hDEADBEEF, 32, 0, 1, 14'h0002, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{8'h03, 16'h0005, 32'h00000000, 32, 0, 0, 14'h0005, 32'hDEADBEEF, 32'h0000003C};
        vecs[2] = '{8'h7F, 16'h1234, 32'hFFFFFFFF, 32, 0, 0, 14'h0005, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{8'h02, 16'h0001, 32'h12345678, 20, 0, 0, 14'h0001, 32'hDEADBEEF, 32'h0};
        vecs[4] = '{8'h02, 16'hC003, 32'h0000A5A5, 32, 0, 1, 14'h0003, 32'h0000A5A5, 32'h0};
        vecs[5] = '{8'h03, 16'hC003, 32'h00000000, 32, 0, 0, 14'h0003, 32'h0000A5A5, 32'hA5A50003};
        vecs[6] = '{8'h02, 16'h3FFF, 32'hFFFFFFFF, 32, 1, 1, 14'h3FFF, 32'hFFFFFFFF, 32'h0};
        vecs[7] = '{8'h03, 16'h0000, 32'h00000000, 32, 0, 0, 14'h0000, 32'hFFFFFFFF, VERSION};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_write", {31'd0, wr}, 32'd0);
        chk("reset_addr", {18'd0, addr}, 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        chk("reset_miso", {31'd0, miso}, 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].exp_wr) exp_q.push_back('{vecs[k].exp_addr, vecs[k].exp_wdata});
            frame(vecs[k].cmd, vecs[k].addr, vecs[k].data, vecs[k].ndata, vecs[k].coinc, -1, mw, mnz);
            chk($sformatf("v%0d_write_seen", k), exp_q.size(), 32'd0);
            exp_q.delete();
            chk($sformatf("v%0d_addr", k), {18'd0, addr}, {18'd0, vecs[k].exp_addr});
            chk($sformatf("v%0d_wdata", k), wdata, vecs[k].exp_wdata);
            if (vecs[k].cmd == 8'h03)
                chk($sformatf("v%0d_miso", k), mw, vecs[k].exp_miso);
            else
                chk($sformatf("v%0d_miso_quiet", k), {31'd0, mnz}, 32'd0);
        end

        // Reset during the data phase of a read; rest of that frame must be inert.
        frame(8'h03, 16'h0005, 32'h0, 32, 0, 32, mw, mnz);
        chk("rst_frame_miso_quiet", {31'd0, mnz}, 32'd0);
        chk("rst_frame_addr", {18'd0, addr}, 32'd0);
        chk("rst_frame_wdata", wdata, 32'd0);

        frame(8'h03, 16'h0000, 32'h0, 32, 0, -1, mw, mnz);
        chk("post_rst_version", mw, VERSION);
        chk("post_rst_addr", {18'd0, addr}, 32'd0);
        chk("post_rst_wdata", wdata, 32'd0);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
